// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master = producer of operations and consumer of results; slave = the pipeline.
interface addsub_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_z;
  logic             out_c;
  logic             out_o;
  logic             out_n;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_z, out_c, out_o, out_n
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_z, out_c, out_o, out_n
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit carry segment per stage,
// Z/C/O/N flags registered with the result, global stall on output back-pressure.
module addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus
);
  localparam int LAT = WIDTH / CHUNK;

  logic adv;

  // Every stage moves together; a held result freezes the whole pipe.
  assign adv          = !g_stage[LAT-1].valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  genvar gi;
  for (gi = 0; gi < LAT; gi++) begin : g_stage
    localparam int IN_W  = WIDTH - gi * CHUNK;
    localparam int RES_W = (gi + 1) * CHUNK;

    logic [IN_W-1:0]  a_src;
    logic [IN_W-1:0]  b_src;
    logic             c_src;
    logic             v_src;
    logic [TAG_W-1:0] t_src;
    logic [CHUNK:0]   sum;

    logic             valid_d, valid_q;
    logic             carry_d, carry_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [RES_W-1:0] res_d, res_q;

    // Operand B is inverted once at entry, so later stages are plain adders.
    if (gi == 0) begin : g_src
      assign a_src = bus.in_a;
      assign b_src = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign c_src = bus.in_sub;
      assign v_src = bus.in_valid;
      assign t_src = bus.in_tag;
      always_comb res_d = sum[CHUNK-1:0];
    end else begin : g_src
      assign a_src = g_stage[gi-1].g_ops.a_q;
      assign b_src = g_stage[gi-1].g_ops.b_q;
      assign c_src = g_stage[gi-1].carry_q;
      assign v_src = g_stage[gi-1].valid_q;
      assign t_src = g_stage[gi-1].tag_q;
      always_comb res_d = {sum[CHUNK-1:0], g_stage[gi-1].res_q};
    end

    assign sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, c_src};

    always_comb begin
      valid_d = v_src;
      carry_d = sum[CHUNK];
      tag_d   = t_src;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        tag_q   <= '0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        tag_q   <= tag_d;
        res_q   <= res_d;
      end
    end

    // Only the not-yet-added operand chunks travel on, LSB-aligned to the next chunk.
    if (gi < LAT - 1) begin : g_ops
      logic [IN_W-CHUNK-1:0] a_d, a_q;
      logic [IN_W-CHUNK-1:0] b_d, b_q;

      always_comb begin
        a_d = a_src[IN_W-1:CHUNK];
        b_d = b_src[IN_W-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // With B pre-inverted for subtraction, one overflow rule covers both operations.
    if (gi == LAT - 1) begin : g_flags
      logic z_d, z_q;
      logic o_d, o_q;

      always_comb begin
        z_d = (res_d == '0);
        o_d = (a_src[IN_W-1] == b_src[IN_W-1]) && (sum[CHUNK-1] != a_src[IN_W-1]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          z_q <= 1'b0;
          o_q <= 1'b0;
        end else if (adv) begin
          z_q <= z_d;
          o_q <= o_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[LAT-1].valid_q;
  assign bus.out_res   = g_stage[LAT-1].res_q;
  assign bus.out_tag   = g_stage[LAT-1].tag_q;
  assign bus.out_c     = g_stage[LAT-1].carry_q;
  assign bus.out_z     = g_stage[LAT-1].g_flags.z_q;
  assign bus.out_o     = g_stage[LAT-1].g_flags.o_q;
  assign bus.out_n     = g_stage[LAT-1].res_q[WIDTH-1];
endmodule
